// File: rtl/multi_cycle_ctrl_fsm_pkg.sv
// rtl/multi_cycle_ctrl_fsm_pkg.sv - shared encodings for the multi-cycle control FSM
// Purpose: state encodings, RV32I opcode constants, ALU select encodings and
//          an opcode-class decoder shared by the controller and its bench.
// Ports:   none (package).
package multi_cycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_BR  = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_JAL, CLS_JALR, CLS_ECALL, CLS_ILL
  } op_class_t;

  function automatic op_class_t decode_class(input logic [6:0] op);
    case (op)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LW:     return CLS_LW;
      OP_SW:     return CLS_SW;
      OP_BRANCH: return CLS_BR;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_ECALL:  return CLS_ECALL;
      default:   return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_fsm_mem_wait_timer.sv
// rtl/multi_cycle_ctrl_fsm_mem_wait_timer.sv - memory wait-cycle counter with expiry compare
// Purpose: counts consecutive cycles a memory access is stalled; flags expiry
//          in the TIMEOUT-th stalled cycle so the FSM can halt on the next edge.
// Ports:   clk, reset_n (async active-low), waiting_i (access stalled this cycle),
//          expired_o (this is the TIMEOUT-th consecutive stalled cycle).
module mem_wait_timer #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic waiting_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle that is not a stall (ready arrived or FSM left IF/MEM) restarts the count.
  assign cnt_d     = waiting_i ? cnt_q + 1'b1 : '0;
  assign expired_o = waiting_i && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_cycle_ctrl_fsm.sv
// rtl/multi_cycle_ctrl_fsm.sv - RV32I multi-cycle core control FSM
// Purpose: owns the controller state register and decodes datapath enables and
//          selects from state + IR opcode, with memory handshake, branch
//          sequencing, ECALL halt, illegal-opcode trap and memory timeout.
// Ports:   clk, reset_n; opcode, bcond, halt_req, mem_ready in;
//          PC/memory/IR/regfile strobes, ALU selects, state, is_halted,
//          illegal_instr, mem_timeout out.
module multi_cycle_ctrl_fsm
  import multi_cycle_ctrl_fsm_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_TIMEOUT   = 0,
  parameter int TMO_W         = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       is_halted,
  output logic       illegal_instr,
  output logic       mem_timeout
);

  state_t    state_q, state_d;
  op_class_t cls;
  logic      rdy;
  logic      tmo_expired;
  logic      mem_timeout_q;

  assign cls = decode_class(opcode);
  assign rdy = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

  if (MEM_TIMEOUT > 0) begin : g_timer
    logic waiting;
    assign waiting = ((state_q == S_IF) || (state_q == S_MEM)) && !rdy;
    mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT), .CNT_W(TMO_W)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .waiting_i (waiting),
      .expired_o (tmo_expired)
    );
  end else begin : g_no_timer
    assign tmo_expired = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (tmo_expired) mem_timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: state_d = S_IF;
      S_IF:   state_d = tmo_expired ? S_HALT : (rdy ? S_ID : S_IF);
      S_ID: begin
        if (cls == CLS_ECALL)    state_d = halt_req ? S_HALT : S_IF;
        else if (cls == CLS_ILL) state_d = S_IF;
        else                     state_d = S_EX;
      end
      S_EX: begin
        if (cls == CLS_LW || cls == CLS_SW) state_d = S_MEM;
        else if (cls == CLS_BR)             state_d = bcond ? S_IF : S_WB;
        else                                state_d = S_WB;
      end
      S_MEM: begin
        if (tmo_expired) state_d = S_HALT;
        else if (rdy)    state_d = (cls == CLS_LW) ? S_WB : S_IF;
      end
      S_WB:    state_d = S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_OP_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = rdy;
      end
      S_ID: begin
        // Default ID work precomputes the branch target PC+imm into ALUOut;
        // ECALL-without-halt and illegal opcodes instead retire with PC+4.
        alu_src_b = SRCB_IMM;
        if ((cls == CLS_ECALL && !halt_req) || cls == CLS_ILL) begin
          pc_write  = 1'b1;
          alu_src_b = SRCB_FOUR;
        end
        illegal_instr = (cls == CLS_ILL);
      end
      S_EX: begin
        case (cls)
          CLS_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_R;
          end
          CLS_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_OP_I;
          end
          CLS_LW, CLS_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
          end
          CLS_JAL, CLS_JALR: alu_src_b = SRCB_FOUR;
          CLS_BR: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_OP_BR;
            pc_write_cond = 1'b1;
            pc_source     = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (cls == CLS_LW) mem_read = 1'b1;
        if (cls == CLS_SW) begin
          mem_write = 1'b1;
          if (rdy) begin
            pc_write  = 1'b1;
            alu_src_b = SRCB_FOUR;
          end
        end
      end
      S_WB: begin
        pc_write = 1'b1;
        case (cls)
          CLS_R, CLS_I, CLS_LW: begin
            reg_write  = 1'b1;
            mem_to_reg = (cls == CLS_LW);
            alu_src_b  = SRCB_FOUR;
          end
          CLS_JAL: begin
            reg_write = 1'b1;
            alu_src_b = SRCB_IMM;
          end
          CLS_JALR: begin
            reg_write = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
          end
          default: alu_src_b = SRCB_FOUR;
        endcase
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign is_halted   = (state_q == S_HALT);
  assign mem_timeout = mem_timeout_q;

endmodule
